pulse_sync_rx_multi: RTL and testbench

//  Multi-channel receive side of a toggle-based pulse synchroniser, in the dst_clk domain.

---
 rtl/pulse_sync_rx_multi.sv | 143 ++++++++++++++
 tb/tb_pulse_sync_rx_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel toggle-to-pulse receiver with a per-channel pending-event queue.
// Define PULSE_SYNC_OVF_EN to add sticky overflow flags (ovf_flag / ovf_clr).
module pulse_sync_rx_multi #(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 1,
    parameter int CNT_W       = 3
) (
    input  logic              dst_clk,
    input  logic              dst_rst,
    input  logic [CH_NUM-1:0] src_toggle,
    output logic [CH_NUM-1:0] dst_pulse,
    output logic [CH_NUM-1:0] dst_busy
`ifdef PULSE_SYNC_OVF_EN
    ,
    output logic [CH_NUM-1:0] ovf_flag,
    input  logic [CH_NUM-1:0] ovf_clr
`endif
);

    localparam int WU_W = $clog2(SYNC_STAGES + 2);
    localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic [WU_W-1:0] wu_cnt;
    logic            warm;

    assign warm = (wu_cnt != '0);

    // Warm-up lets the chains fill so the level at reset release is the baseline
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            wu_cnt <= WU_INIT;
        end else if (warm) begin
            wu_cnt <= wu_cnt - 1'b1;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   evt;
        logic                   evt_q;
        state_t                 state_q;
        state_t                 state_d;
        logic [PW_W-1:0]        wcnt_q;
        logic [PW_W-1:0]        wcnt_d;
        logic [CNT_W-1:0]       pend_q;
        logic [CNT_W-1:0]       pend_d;
        logic                   start;
        logic                   take;
        logic                   drop;
        logic                   pulse_q;
        logic                   busy_q;

        assign evt = ~warm & (sync_q[SYNC_STAGES-1] ^ prev_q);

        always_comb begin
            state_d = state_q;
            wcnt_d  = wcnt_q;
            start   = 1'b0;
            unique case (state_q)
                S_PULSE: begin
                    if (wcnt_q == '0) begin
                        state_d = S_GAP;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
                S_IDLE, S_GAP: begin
                    state_d = S_IDLE;
                    if (evt_q || (pend_q != '0)) begin
                        start   = 1'b1;
                        state_d = S_PULSE;
                        wcnt_d  = PW_LAST;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A fresh event is served directly; the queue only feeds an idle slot
        always_comb begin
            take   = start & ~evt_q;
            drop   = evt_q & ~start & (pend_q == '1);
            pend_d = pend_q;
            if (evt_q && !start && !drop) begin
                pend_d = pend_q + 1'b1;
            end else if (take) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_ff @(posedge dst_clk) begin
            if (dst_rst) begin
                sync_q  <= '0;
                prev_q  <= 1'b0;
                evt_q   <= 1'b0;
                state_q <= S_IDLE;
                wcnt_q  <= '0;
                pend_q  <= '0;
                pulse_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], src_toggle[i]};
                prev_q  <= sync_q[SYNC_STAGES-1];
                evt_q   <= evt;
                state_q <= state_d;
                wcnt_q  <= wcnt_d;
                pend_q  <= pend_d;
                pulse_q <= (state_d == S_PULSE);
                busy_q  <= (state_d != S_IDLE) || (pend_d != '0);
            end
        end

        assign dst_pulse[i] = pulse_q;
        assign dst_busy[i]  = busy_q;

`ifdef PULSE_SYNC_OVF_EN
        logic ovf_q;

        always_ff @(posedge dst_clk) begin
            if (dst_rst) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr[i]) begin
                ovf_q <= 1'b0;
            end
        end

        assign ovf_flag[i] = ovf_q;
`endif
    end

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Bench for pulse_sync_rx_multi: event-queue reference model, directed and random tests.
// Compile with PULSE_SYNC_OVF_EN defined to also cover the overflow flags.
module tb_pulse_sync_rx_multi;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int W    = 4;
    localparam int CW   = 2;
    localparam int MAXP = (1 << CW) - 1;

    logic          dst_clk = 1'b0;
    logic          dst_rst = 1'b1;
    logic [CH-1:0] src_toggle = '0;
    logic [CH-1:0] ovf_clr = '0;
    logic [CH-1:0] dst_pulse;
    logic [CH-1:0] dst_busy;
`ifdef PULSE_SYNC_OVF_EN
    logic [CH-1:0] ovf_flag;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int pend[CH];
    int free_at[CH];
    int last_start[CH];
    int last_chg[CH];
    int arr_q[CH][$];
    logic [CH-1:0] exp_pulse;
    logic [CH-1:0] exp_busy;
    logic [CH-1:0] exp_ovf;

    always #5 dst_clk = ~dst_clk;

    pulse_sync_rx_multi #(
        .CH_NUM(CH), .SYNC_STAGES(S), .PULSE_W(W), .CNT_W(CW)
    ) dut (
        .dst_clk   (dst_clk),
        .dst_rst   (dst_rst),
        .src_toggle(src_toggle),
        .dst_pulse (dst_pulse),
        .dst_busy  (dst_busy)
`ifdef PULSE_SYNC_OVF_EN
        ,
        .ovf_flag  (ovf_flag),
        .ovf_clr   (ovf_clr)
`endif
    );

    // Reference: each event joins a queue and is served as soon as the channel
    // is free; a channel is free again W+1 edges after a pulse starts.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            if (dst_rst) begin
                pend[c] = 0;
                free_at[c] = 0;
                last_start[c] = -1000;
                exp_ovf[c] = 1'b0;
                arr_q[c].delete();
            end else begin
                int avail;
                bit dropped;
                avail = pend[c];
                dropped = 0;
                if (arr_q[c].size() > 0 && arr_q[c][0] == cyc) begin
                    void'(arr_q[c].pop_front());
                    avail++;
                end
                if (cyc >= free_at[c] && avail > 0) begin
                    last_start[c] = cyc;
                    free_at[c] = cyc + W + 1;
                    pend[c] = avail - 1;
                end else if (avail > MAXP) begin
                    pend[c] = MAXP;
                    dropped = 1;
                end else begin
                    pend[c] = avail;
                end
                if (dropped) exp_ovf[c] = 1'b1;
                else if (ovf_clr[c]) exp_ovf[c] = 1'b0;
            end
            exp_pulse[c] = !dst_rst && cyc >= last_start[c] && cyc < last_start[c] + W;
            exp_busy[c] = !dst_rst && (cyc < free_at[c] || pend[c] > 0);
        end
    endtask

    task automatic step();
        @(posedge dst_clk);
        cyc++;
        model_edge();
        #1;
    endtask

    // Level change now is first sampled at edge cyc+1; served at cyc+1+S+1
    task automatic toggle(input int c);
        src_toggle[c] = ~src_toggle[c];
        arr_q[c].push_back(cyc + S + 2);
        last_chg[c] = cyc;
    endtask

    task automatic test_reset();
        dst_rst = 1'b1;
        src_toggle = 4'b1010;
        repeat (2) step();
        checks++;
        if (dst_pulse !== 4'b0 || dst_busy !== 4'b0) begin
            errors++;
            $display("FAIL reset_state pulse=%b busy=%b want 0000/0000", dst_pulse, dst_busy);
        end
`ifdef PULSE_SYNC_OVF_EN
        checks++;
        if (ovf_flag !== 4'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b want 0000", ovf_flag);
        end
`endif
        dst_rst = 1'b0;
        repeat (20) begin
            step();
            checks++;
            if (dst_pulse !== 4'b0) begin
                errors++;
                $display("FAIL warmup_pulse cyc=%0d got=%b want 0000", cyc, dst_pulse);
            end
            checks++;
            if (dst_busy !== 4'b0) begin
                errors++;
                $display("FAIL warmup_busy cyc=%0d got=%b want 0000", cyc, dst_busy);
            end
        end
    endtask

    task automatic test_single();
        int t0;
        int first;
        int hi;
        first = -1;
        hi = 0;
        toggle(0);
        t0 = cyc;
        repeat (14) begin
            step();
            checks++;
            if (dst_pulse !== exp_pulse || dst_busy !== exp_busy) begin
                errors++;
                $display("FAIL single cyc=%0d pulse=%b busy=%b want %b/%b",
                         cyc, dst_pulse, dst_busy, exp_pulse, exp_busy);
            end
            checks++;
            if (dst_pulse[3:1] !== 3'b0) begin
                errors++;
                $display("FAIL single_other cyc=%0d got=%b want 000", cyc, dst_pulse[3:1]);
            end
            if (dst_pulse[0]) begin
                hi++;
                if (first < 0) first = cyc;
            end
        end
        checks++;
        if (first !== t0 + S + 2) begin
            errors++;
            $display("FAIL single_latency got edge %0d want %0d", first, t0 + S + 2);
        end
        checks++;
        if (hi !== W) begin
            errors++;
            $display("FAIL single_width got=%0d want=%0d", hi, W);
        end
    endtask

    task automatic test_burst();
        int rises;
        logic prev;
        rises = 0;
        prev = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n % 3 == 0 && n < 12) toggle(1);
            step();
            checks++;
            if (dst_pulse !== exp_pulse || dst_busy !== exp_busy) begin
                errors++;
                $display("FAIL burst cyc=%0d pulse=%b busy=%b want %b/%b",
                         cyc, dst_pulse, dst_busy, exp_pulse, exp_busy);
            end
            if (dst_pulse[1] && !prev) rises++;
            prev = dst_pulse[1];
        end
        checks++;
        if (rises !== 4) begin
            errors++;
            $display("FAIL burst_count got=%0d want=4", rises);
        end
        checks++;
        if (dst_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL burst_busy_end got=%b want 0", dst_busy[1]);
        end
    endtask

    task automatic test_overflow();
        int rises;
        int set_with_clr;
        logic prev;
        rises = 0;
        set_with_clr = 0;
        prev = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (n % 3 == 0 && n < 36) toggle(2);
            ovf_clr[2] = (n >= 34 && n < 46);
            step();
            checks++;
            if (dst_pulse !== exp_pulse || dst_busy !== exp_busy) begin
                errors++;
                $display("FAIL overflow cyc=%0d pulse=%b busy=%b want %b/%b",
                         cyc, dst_pulse, dst_busy, exp_pulse, exp_busy);
            end
`ifdef PULSE_SYNC_OVF_EN
            checks++;
            if (ovf_flag !== exp_ovf) begin
                errors++;
                $display("FAIL ovf_flag cyc=%0d got=%b want=%b", cyc, ovf_flag, exp_ovf);
            end
            if (ovf_clr[2] && ovf_flag[2]) set_with_clr++;
            if (n == 33) begin
                checks++;
                if (ovf_flag[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_raised got=%b want 1", ovf_flag[2]);
                end
            end
`endif
            if (dst_pulse[2] && !prev) rises++;
            prev = dst_pulse[2];
        end
        ovf_clr = '0;
        checks++;
        if (rises !== 10) begin
            errors++;
            $display("FAIL overflow_count got=%0d want=10", rises);
        end
`ifdef PULSE_SYNC_OVF_EN
        checks++;
        if (set_with_clr < 1) begin
            errors++;
            $display("FAIL ovf_set_wins got=%0d want>=1", set_with_clr);
        end
        checks++;
        if (ovf_flag[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared got=%b want 0", ovf_flag[2]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int k;
        for (int n = 0; n < 20; n++) begin
            if (n % 3 == 0 && n < 18) toggle(3);
            step();
            checks++;
            if (dst_pulse !== exp_pulse || dst_busy !== exp_busy) begin
                errors++;
                $display("FAIL rstmid_fill cyc=%0d pulse=%b busy=%b want %b/%b",
                         cyc, dst_pulse, dst_busy, exp_pulse, exp_busy);
            end
        end
        k = 0;
        while (!dst_pulse[3] && k < 10) begin
            step();
            k++;
        end
        checks++;
        if (dst_pulse[3] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_wait got=%b want 1 within 10 cycles", dst_pulse[3]);
        end
        dst_rst = 1'b1;
        step();
        checks++;
        if (dst_pulse !== 4'b0 || dst_busy !== 4'b0) begin
            errors++;
            $display("FAIL rstmid_drop pulse=%b busy=%b want 0000/0000", dst_pulse, dst_busy);
        end
        dst_rst = 1'b0;
        repeat (30) begin
            step();
            checks++;
            if (dst_pulse !== 4'b0 || dst_busy !== 4'b0) begin
                errors++;
                $display("FAIL rstmid_quiet cyc=%0d pulse=%b busy=%b want 0000/0000",
                         cyc, dst_pulse, dst_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (cyc - last_chg[c] >= S + 1 && $urandom_range(0, 2) == 0) toggle(c);
                ovf_clr[c] = ($urandom_range(0, 7) == 0);
            end
            step();
            checks++;
            if (dst_pulse !== exp_pulse || dst_busy !== exp_busy) begin
                errors++;
                $display("FAIL random cyc=%0d pulse=%b busy=%b want %b/%b",
                         cyc, dst_pulse, dst_busy, exp_pulse, exp_busy);
            end
`ifdef PULSE_SYNC_OVF_EN
            checks++;
            if (ovf_flag !== exp_ovf) begin
                errors++;
                $display("FAIL random_ovf cyc=%0d got=%b want=%b", cyc, ovf_flag, exp_ovf);
            end
`endif
        end
        ovf_clr = '0;
        repeat (60) step();
        checks++;
        if (dst_busy !== 4'b0 || dst_busy !== exp_busy) begin
            errors++;
            $display("FAIL random_drain busy=%b want 0000", dst_busy);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) last_chg[c] = -100;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d still running", cyc);
        $fatal(1, "watchdog");
    end

endmodule
